// File: rtl/eda_pkg.sv
// Shared types and constants for the regional-max flood stage.
package eda_pkg;

    localparam int unsigned CFG_ADDR_WIDTH = 16;
    localparam int unsigned NUM_DIRS       = 8;
    localparam int unsigned DIR_W          = 3;
    localparam int unsigned IDLE_CNT_W     = 4;

    typedef logic [DIR_W-1:0] dir_t;

    localparam dir_t DIR_UPLEFT    = 3'd0;
    localparam dir_t DIR_UP        = 3'd1;
    localparam dir_t DIR_UPRIGHT   = 3'd2;
    localparam dir_t DIR_LEFT      = 3'd3;
    localparam dir_t DIR_RIGHT     = 3'd4;
    localparam dir_t DIR_DOWNLEFT  = 3'd5;
    localparam dir_t DIR_DOWN      = 3'd6;
    localparam dir_t DIR_DOWNRIGHT = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } drain_state_t;

    // Direction d lives on flag/strobe bit 7-d.
    function automatic logic [NUM_DIRS-1:0] dir_to_bit(input dir_t d);
        logic [NUM_DIRS-1:0] b;
        b = '0;
        b[DIR_DOWNRIGHT - d] = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/eda_rr_pick.sv
// 8-way rotating-priority encoder: first set req at or after ptr, wrapping.
module eda_rr_pick
    import eda_pkg::*;
(
    input  logic [NUM_DIRS-1:0] req,
    input  dir_t                ptr,
    output logic                gnt_vld,
    output dir_t                gnt_idx
);

    dir_t cand;

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = int'(NUM_DIRS) - 1; i >= 0; i--) begin
            cand = ptr + DIR_W'(i);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/eda_fifo_drain.sv
// Round-robin pop scheduler for the eight neighbour FIFOs with drain detection.
// Optional duplicate-address suppression enabled by EDA_DRAIN_DEDUP_EN.
module eda_fifo_drain
    import eda_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = CFG_ADDR_WIDTH,
    parameter int unsigned DONE_IDLE_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_DIRS-1:0]            fifo_empty,
    input  logic [NUM_DIRS*ADDR_WIDTH-1:0] fifo_data,
    output logic [NUM_DIRS-1:0]            read_en,
    output logic [ADDR_WIDTH-1:0]          pix_addr,
    output dir_t                           pix_dir,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic                           busy,
    output logic                           done
);

    drain_state_t              state_q, state_d;
    dir_t                      ptr_q, ptr_d;
    logic [IDLE_CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic                      pix_valid_d;
    logic [ADDR_WIDTH-1:0]     pix_addr_d;
    dir_t                      pix_dir_d;

    logic [NUM_DIRS-1:0]       req;
    logic [ADDR_WIDTH-1:0]     head [NUM_DIRS];
    logic                      gnt_vld;
    dir_t                      gnt_idx;
    logic [ADDR_WIDTH-1:0]     gnt_addr_c;
    logic                      slot_free_c;
    logic                      pop_c;
    logic                      dup_c;
    logic                      emit_c;

    // Re-index flags and heads by direction.
    for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
        assign req[d]  = ~fifo_empty[NUM_DIRS-1-d];
        assign head[d] = fifo_data[(NUM_DIRS-1-d)*ADDR_WIDTH +: ADDR_WIDTH];
    end

    eda_rr_pick u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign gnt_addr_c  = head[gnt_idx];
    assign slot_free_c = ~pix_valid | pix_ready;
    assign pop_c       = (state_q == DRAIN) & gnt_vld & slot_free_c;
    assign emit_c      = pop_c & ~dup_c;

`ifdef EDA_DRAIN_DEDUP_EN
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic                  last_vld_q;

    assign dup_c = last_vld_q & (gnt_addr_c == last_addr_q);

    // Last emitted address, forgotten at the start of each region.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
        end else if (state_q == IDLE && start) begin
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
        end else if (emit_c) begin
            last_addr_q <= gnt_addr_c;
            last_vld_q  <= 1'b1;
        end
    end
`else
    assign dup_c = 1'b0;
`endif

    // Next-state, pop strobe and output-register updates.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idle_cnt_d  = idle_cnt_q;
        pix_valid_d = pix_valid;
        pix_addr_d  = pix_addr;
        pix_dir_d   = pix_dir;
        read_en     = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = DRAIN;
                    ptr_d      = '0;
                    idle_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (pop_c) begin
                    read_en = dir_to_bit(gnt_idx);
                    ptr_d   = gnt_idx + dir_t'(1);
                    if (emit_c) begin
                        pix_valid_d = 1'b1;
                        pix_addr_d  = gnt_addr_c;
                        pix_dir_d   = gnt_idx;
                    end else begin
                        pix_valid_d = 1'b0;
                    end
                end else if (pix_valid && pix_ready) begin
                    pix_valid_d = 1'b0;
                end

                if (&fifo_empty && !pix_valid) begin
                    idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
                    if (idle_cnt_d == IDLE_CNT_W'(DONE_IDLE_CYCLES)) begin
                        state_d = DONE;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            idle_cnt_q <= '0;
            pix_valid  <= 1'b0;
            pix_addr   <= '0;
            pix_dir    <= DIR_UPLEFT;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idle_cnt_q <= idle_cnt_d;
            pix_valid  <= pix_valid_d;
            pix_addr   <= pix_addr_d;
            pix_dir    <= pix_dir_d;
            busy       <= (state_d != IDLE);
            done       <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_eda_fifo_drain.sv
// Directed self-checking bench for eda_fifo_drain with a FWFT FIFO model.
module tb_eda_fifo_drain;
    import eda_pkg::*;

    localparam int unsigned AW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [7:0]      fifo_empty;
    logic [8*AW-1:0] fifo_data;
    logic [7:0]      read_en;
    logic [AW-1:0]   pix_addr;
    dir_t            pix_dir;
    logic            pix_valid;
    logic            pix_ready;
    logic            busy;
    logic            done;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] mem [8][64];
    logic [5:0]    wr [8] = '{default: 6'd0};
    logic [5:0]    rd [8] = '{default: 6'd0};

    int            pop_cnt = 0;
    int            bad_pop = 0;
    int            acc_n   = 0;
    logic [AW-1:0] acc_addr [128];

    eda_fifo_drain dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .read_en    (read_en),
        .pix_addr   (pix_addr),
        .pix_dir    (pix_dir),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always_comb begin
        fifo_empty = '1;
        fifo_data  = '0;
        for (int d = 0; d < 8; d++) begin
            fifo_empty[7-d]          = (rd[d] == wr[d]);
            fifo_data[(7-d)*AW +: AW] = mem[d][rd[d]];
        end
    end

    // FIFO pops, strobe legality, accepted-output log.
    always @(posedge clk) begin
        if ($countones(read_en) > 1) bad_pop++;
        if (!busy && read_en != 8'h00) bad_pop++;
        for (int d = 0; d < 8; d++) begin
            if (read_en[7-d]) begin
                if (rd[d] == wr[d]) bad_pop++;
                rd[d] <= rd[d] + 6'd1;
                pop_cnt++;
            end
        end
        if (pix_valid && pix_ready && acc_n < 128) begin
            acc_addr[acc_n] = pix_addr;
            acc_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic push(input int d, input logic [AW-1:0] a);
        mem[d][wr[d]] = a;
        wr[d] = wr[d] + 6'd1;
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pix_valid); end
        checks++; if (read_en !== 8'h00) begin failures++; $display("FAIL reset_read_en got=%h exp=00", read_en); end
        checks++; if (pix_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", pix_addr); end
        checks++; if (pix_dir !== 3'd0) begin failures++; $display("FAIL reset_dir got=%0d exp=0", pix_dir); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        int n;
        @(posedge clk); #1 push(6, 16'h0123); pix_ready = 1'b1;
        @(negedge clk);
        checks++; if (read_en !== 8'h00) begin failures++; $display("FAIL single_idle_read_en got=%h exp=00", read_en); end
        do_start();
        @(negedge clk);
        checks++; if (read_en !== 8'h02) begin failures++; $display("FAIL single_read_en got=%h exp=02", read_en); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        @(posedge clk); @(negedge clk);
        checks++; if (pix_valid !== 1'b1 || pix_addr !== 16'h0123 || pix_dir !== 3'd6)
            begin failures++; $display("FAIL single_out got v=%b a=%h d=%0d exp v=1 a=0123 d=6", pix_valid, pix_addr, pix_dir); end
        checks++; if (read_en !== 8'h00) begin failures++; $display("FAIL single_read_en_after got=%h exp=00", read_en); end
        wait_done(n);
        checks++; if (n != 5) begin failures++; $display("FAIL single_done_latency got=%0d exp=5", n); end
        @(posedge clk); @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_done_pulse got done=%b busy=%b exp 0 0", done, busy); end
    endtask

    task automatic test_fairness();
        int n;
        int p0;
        logic [AW-1:0] exp_addr;
        dir_t exp_dir;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++)
            for (int d = 0; d < 8; d++) push(d, 16'h0A00 + 16'(d*16 + k));
        pix_ready = 1'b1;
        p0 = pop_cnt;
        do_start();
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); @(negedge clk);
            exp_dir  = 3'(i % 8);
            exp_addr = 16'h0A00 + 16'((i % 8)*16 + i/8);
            checks++;
            if (pix_valid !== 1'b1 || pix_dir !== exp_dir || pix_addr !== exp_addr) begin
                failures++;
                $display("FAIL fair_out[%0d] got v=%b d=%0d a=%h exp v=1 d=%0d a=%h", i, pix_valid, pix_dir, pix_addr, exp_dir, exp_addr);
            end
        end
        wait_done(n);
        checks++; if (n != 5) begin failures++; $display("FAIL fair_done_latency got=%0d exp=5", n); end
        checks++; if (pop_cnt - p0 != 24) begin failures++; $display("FAIL fair_pops got=%0d exp=24", pop_cnt - p0); end
    endtask

    task automatic test_back_to_back();
        int n;
        int p0;
        @(posedge clk); #1 push(3, 16'h0300); push(4, 16'h0400); pix_ready = 1'b0;
        p0 = pop_cnt;
        do_start();
        @(negedge clk);
        checks++; if (read_en !== 8'h10) begin failures++; $display("FAIL bp_first_read_en got=%h exp=10", read_en); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (pix_valid !== 1'b1 || pix_addr !== 16'h0300 || pix_dir !== 3'd3 || read_en !== 8'h00) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v=%b a=%h d=%0d re=%h exp v=1 a=0300 d=3 re=00", k, pix_valid, pix_addr, pix_dir, read_en);
            end
        end
        checks++; if (pop_cnt - p0 != 1) begin failures++; $display("FAIL bp_pops got=%0d exp=1", pop_cnt - p0); end
        @(posedge clk); #1 pix_ready = 1'b1;
        @(negedge clk);
        checks++; if (read_en !== 8'h08) begin failures++; $display("FAIL bp_resume_read_en got=%h exp=08", read_en); end
        @(posedge clk); @(negedge clk);
        checks++; if (pix_valid !== 1'b1 || pix_addr !== 16'h0400 || pix_dir !== 3'd4)
            begin failures++; $display("FAIL bp_second got v=%b a=%h d=%0d exp v=1 a=0400 d=4", pix_valid, pix_addr, pix_dir); end
        wait_done(n);
        checks++; if (n != 5) begin failures++; $display("FAIL bp_done_latency got=%0d exp=5", n); end
    endtask

    task automatic test_late_push();
        int n;
        int early;
        @(posedge clk); #1 push(1, 16'h0011); pix_ready = 1'b1;
        do_start();
        @(posedge clk); @(negedge clk);
        checks++; if (pix_valid !== 1'b1 || pix_dir !== 3'd1 || pix_addr !== 16'h0011)
            begin failures++; $display("FAIL late_first got v=%b a=%h d=%0d exp v=1 a=0011 d=1", pix_valid, pix_addr, pix_dir); end
        early = 0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            if (done === 1'b1) early++;
        end
        @(posedge clk); #1 push(3, 16'h0333);
        @(negedge clk);
        checks++; if (read_en !== 8'h10) begin failures++; $display("FAIL late_read_en got=%h exp=10", read_en); end
        @(posedge clk); @(negedge clk);
        checks++; if (pix_valid !== 1'b1 || pix_dir !== 3'd3 || pix_addr !== 16'h0333)
            begin failures++; $display("FAIL late_out got v=%b a=%h d=%0d exp v=1 a=0333 d=3", pix_valid, pix_addr, pix_dir); end
        wait_done(n);
        checks++; if (n != 5 || early != 0) begin failures++; $display("FAIL late_done got latency=%0d early=%0d exp 5 0", n, early); end
    endtask

    task automatic test_reset_mid();
        int n;
        @(posedge clk); #1 push(0, 16'h0500); push(0, 16'h0501); push(5, 16'h0505); pix_ready = 1'b0;
        do_start();
        @(posedge clk); @(negedge clk);
        checks++; if (pix_valid !== 1'b1 || pix_addr !== 16'h0500) begin failures++; $display("FAIL rst_pre got v=%b a=%h exp v=1 a=0500", pix_valid, pix_addr); end
        pix_ready = 1'b1;
        #1;
        checks++; if (read_en !== 8'h04) begin failures++; $display("FAIL rst_pre_read_en got=%h exp=04", read_en); end
        reset = 1'b1;
        #1;
        checks++; if (pix_valid !== 1'b0 || read_en !== 8'h00 || busy !== 1'b0)
            begin failures++; $display("FAIL rst_async got v=%b re=%h busy=%b exp 0 00 0", pix_valid, read_en, busy); end
        @(posedge clk); #1 reset = 1'b0;
        do_start();
        @(negedge clk);
        checks++; if (read_en !== 8'h80) begin failures++; $display("FAIL rst_ptr_restart got=%h exp=80", read_en); end
        @(posedge clk); @(negedge clk);
        checks++; if (pix_valid !== 1'b1 || pix_addr !== 16'h0501 || pix_dir !== 3'd0)
            begin failures++; $display("FAIL rst_resume_out got v=%b a=%h d=%0d exp v=1 a=0501 d=0", pix_valid, pix_addr, pix_dir); end
        wait_done(n);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL rst_done got=%b exp=1", done); end
    endtask

    task automatic test_dedup();
        int n;
        int a0;
        int p0;
        @(posedge clk); #1 push(1, 16'h0040); push(1, 16'h0040); push(1, 16'h0041); pix_ready = 1'b1;
        a0 = acc_n;
        p0 = pop_cnt;
        do_start();
        wait_done(n);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL dedup_done got=%b exp=1", done); end
        checks++; if (pop_cnt - p0 != 3) begin failures++; $display("FAIL dedup_pops got=%0d exp=3", pop_cnt - p0); end
`ifdef EDA_DRAIN_DEDUP_EN
        checks++; if (acc_n - a0 != 2) begin failures++; $display("FAIL dedup_outputs got=%0d exp=2", acc_n - a0); end
        checks++; if (acc_addr[a0] !== 16'h0040 || acc_addr[a0+1] !== 16'h0041)
            begin failures++; $display("FAIL dedup_addrs got=%h,%h exp=0040,0041", acc_addr[a0], acc_addr[a0+1]); end
`else
        checks++; if (acc_n - a0 != 3) begin failures++; $display("FAIL dedup_outputs got=%0d exp=3", acc_n - a0); end
        checks++; if (acc_addr[a0] !== 16'h0040 || acc_addr[a0+1] !== 16'h0040 || acc_addr[a0+2] !== 16'h0041)
            begin failures++; $display("FAIL dedup_addrs got=%h,%h,%h exp=0040,0040,0041", acc_addr[a0], acc_addr[a0+1], acc_addr[a0+2]); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_late_push();
        test_reset_mid();
        test_dedup();
        repeat (2) @(posedge clk);
        checks++; if (bad_pop != 0) begin failures++; $display("FAIL read_en_invariant got=%0d exp=0 violations", bad_pop); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
